// File: rtl/pulse_mon_pkg.sv
// Shared types and defaults for the pulse period monitor and its helpers.
package pulse_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } statetype;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_CNT = 4;
  // Wide enough for the largest legal LOCK_CNT (15).
  localparam int MATCH_W      = 4;

endpackage

// File: rtl/pulse_period_monitor_rise_detect.sv
// Rising-edge detector for a strobe already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic pulse_in,
  output logic rise
);

  logic pulse_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pulse_q <= 1'b0;
    else          pulse_q <= pulse_in;
  end

  assign rise = pulse_in & ~pulse_q;

endmodule

// File: rtl/pulse_period_monitor.sv
// Measures the interval between strobe rising edges, compares it to an
// expected divide ratio and declares lock after LOCK_CNT consecutive matches.
module pulse_period_monitor
  import pulse_mon_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             overflow
);

  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);

  statetype           state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next, period_next;
  logic [MATCH_W-1:0] match_cnt, match_next, match_inc;
  logic               valid_next, locked_next, err_next, ovf_next;
  logic               rise;

  rise_detect u_rise (
    .clk      (clk),
    .reset_n  (reset_n),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    match_next  = match_cnt;
    period_next = period;
    valid_next  = 1'b0;
    locked_next = locked;
    err_next    = 1'b0;
    ovf_next    = 1'b0;
    match_inc   = match_cnt + MATCH_W'(1);

    if (!en) begin
      state_next  = IDLE;
      cnt_next    = '0;
      match_next  = '0;
      locked_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next    = '0;
          match_next  = '0;
          locked_next = 1'b0;
          state_next  = HUNT;
        end
        HUNT: begin
          // First edge only starts the count; there is no interval yet.
          if (rise) begin
            cnt_next   = CNT_ONE;
            state_next = MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            cnt_next    = CNT_ONE;
            period_next = cnt;
            valid_next  = 1'b1;
            if (cnt == exp_period) begin
              if (state == LOCKED) begin
                match_next = LOCK_TGT;
              end else begin
                match_next = match_inc;
                if (match_inc == LOCK_TGT) begin
                  state_next  = LOCKED;
                  locked_next = 1'b1;
                end
              end
            end else begin
              err_next    = 1'b1;
              match_next  = '0;
              locked_next = 1'b0;
              state_next  = MEASURE;
            end
          end else if (cnt == CNT_MAX) begin
            ovf_next    = 1'b1;
            locked_next = 1'b0;
            match_next  = '0;
            cnt_next    = '0;
            state_next  = HUNT;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      match_cnt    <= match_next;
      period       <= period_next;
      period_valid <= valid_next;
      locked       <= locked_next;
      err          <= err_next;
      overflow     <= ovf_next;
    end
  end

endmodule
